// File: rtl/cjtag_packet_rx.sv
// cjtag_packet_rx: deframes a serial TMSC bit stream into length, payload bytes, CRC byte and parity bit.
// Ports: clk, rst_n (sync, active-low); bit_in/bit_valid serial input (MSB first);
// data_out/data_valid/data_last byte stream to the checker; crc_expected/crc_check and
// parity_expected/parity_check compare strobes; pkt_len, pkt_done, frame_error, busy status.
module cjtag_packet_rx #(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       data_last,
    output logic [7:0] crc_expected,
    output logic       crc_check,
    output logic       parity_expected,
    output logic       parity_check,
    output logic [7:0] pkt_len,
    output logic       pkt_done,
    output logic       frame_error,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CRC, PARITY, CLOSE} state_t;
    state_t      state, state_nx;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [15:0] idle_cnt;
    logic [7:0]  byte_val;
    logic        byte_done, timing, timeout, len_ok;
    logic        data_valid_d, data_last_d, crc_check_d, parity_check_d, pkt_done_d, frame_error_d;

    assign byte_val  = {shift[6:0], bit_in};
    assign byte_done = bit_valid && bit_cnt == 3'd7;
    assign timing    = state inside {LEN, PAYLOAD, CRC, PARITY};
    // a bit arriving on the limit cycle keeps the packet alive
    assign timeout   = timing && !bit_valid && idle_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign len_ok    = byte_val != 8'd0 && byte_val <= 8'(MAX_LEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            shift           <= '0;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            idle_cnt        <= '0;
            data_out        <= '0;
            data_valid      <= 1'b0;
            data_last       <= 1'b0;
            crc_expected    <= '0;
            crc_check       <= 1'b0;
            parity_expected <= 1'b0;
            parity_check    <= 1'b0;
            pkt_len         <= '0;
            pkt_done        <= 1'b0;
            frame_error     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state        <= state_nx;
            shift        <= bit_valid ? byte_val : shift;
            // the parity bit ends the frame, so the next length byte starts from bit 0
            bit_cnt      <= (timeout || (state == PARITY && bit_valid)) ? 3'd0 : bit_cnt + 3'(bit_valid);
            byte_cnt     <= (timeout || state == LEN) ? 8'd0 : byte_cnt + 8'(data_valid_d);
            idle_cnt     <= (bit_valid || !timing || timeout) ? 16'd0 : idle_cnt + 16'd1;
            pkt_len      <= (state == LEN && byte_done && len_ok) ? byte_val : pkt_len;
            data_out     <= data_valid_d ? byte_val : data_out;
            crc_expected <= crc_check_d ? byte_val : crc_expected;
            parity_expected <= parity_check_d ? bit_in : parity_expected;
            data_valid   <= data_valid_d;
            data_last    <= data_last_d;
            crc_check    <= crc_check_d;
            parity_check <= parity_check_d;
            pkt_done     <= pkt_done_d;
            frame_error  <= frame_error_d;
            busy         <= state_nx != IDLE;
        end
    end

    always_comb begin
        state_nx = state;
        if (timeout) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = bit_valid ? LEN : IDLE;
                LEN:     state_nx = byte_done ? (len_ok ? PAYLOAD : IDLE) : LEN;
                PAYLOAD: state_nx = (byte_done && 8'(byte_cnt + 8'd1) == pkt_len) ? CRC : PAYLOAD;
                CRC:     state_nx = byte_done ? PARITY : CRC;
                PARITY:  state_nx = bit_valid ? CLOSE : PARITY;
                CLOSE:   state_nx = bit_valid ? LEN : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        data_valid_d   = state == PAYLOAD && byte_done;
        crc_check_d    = state == CRC && byte_done;
        parity_check_d = state == PARITY && bit_valid;
        pkt_done_d     = state == CLOSE;
        // an illegal length never reached the checker, so only later aborts reset it
        data_last_d    = state == CLOSE || (timeout && state != LEN);
        frame_error_d  = timeout || (state == LEN && byte_done && !len_ok);
    end
endmodule
